// File: rtl/xor_seq_arbiter.sv
// Round-robin arbiter that shares one 4-bit ls7486 XOR slice among requesters.
// Operands are walked through the slice one nibble per cycle, LSB nibble first.
module xor_seq_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  localparam int NNIB = WIDTH / 4,
  localparam int IW = $clog2(N_REQ),
  localparam int NW = (NNIB > 1) ? $clog2(NNIB) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [IW-1:0]          done_id,
  output logic [WIDTH-1:0]       result,
  output logic [3:0]             xa,
  output logic [3:0]             xb,
  input  logic [3:0]             xy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    w_r;
  logic [IW-1:0]    win;
  logic [IW-1:0]    idx;
  logic             hit;
  logic [NW-1:0]    nib;
  logic             last;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] acc, acc_nxt;

  // Descending scan so the lowest offset from ptr wins.
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) begin
        sel_a = op_a[i*WIDTH +: WIDTH];
        sel_b = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign last = (nib == NW'(NNIB - 1));

  always_comb begin
    xa = '0;
    xb = '0;
    acc_nxt = acc;
    for (int j = 0; j < NNIB; j++) begin
      if (nib == NW'(j)) begin
        if (state_q == RUN) begin
          xa = a_r[j*4 +: 4];
          xb = b_r[j*4 +: 4];
        end
        acc_nxt[j*4 +: 4] = xy;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (hit) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      w_r     <= '0;
      nib     <= '0;
      gnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      result  <= '0;
      done_id <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            a_r <= sel_a;
            b_r <= sel_b;
            w_r <= win;
            gnt <= N_REQ'(1) << win;
            nib <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          nib <= last ? '0 : nib + 1'b1;
          // Publish at the last capture so result is valid with done.
          if (last) begin
            result  <= acc_nxt;
            done_id <= w_r;
          end
        end
        DONE: begin
          gnt <= '0;
          ptr <= (w_r == IW'(N_REQ - 1)) ? '0 : w_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_seq_arbiter.sv
// Bench for xor_seq_arbiter: 4x16 and 2x8 instances, each with a model slice.
// Expected grants/results come from a round-robin + XOR reference model.
module tb_xor_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic [3:0]  gnt;
  logic        busy, done;
  logic [1:0]  done_id;
  logic [15:0] result;
  logic [3:0]  xa, xb, xy;

  logic [1:0]  req8 = '0;
  logic [15:0] a8 = '0;
  logic [15:0] b8 = '0;
  logic [1:0]  gnt8;
  logic        busy8, done8;
  logic [0:0]  id8;
  logic [7:0]  res8;
  logic [3:0]  xa8, xb8, xy8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign xy  = xa ^ xb;
  assign xy8 = xa8 ^ xb8;

  xor_seq_arbiter #(.N_REQ(4), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .xa(xa), .xb(xb), .xy(xy)
  );

  xor_seq_arbiter #(.N_REQ(2), .WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .op_a(a8), .op_b(b8),
    .gnt(gnt8), .busy(busy8), .done(done8), .done_id(id8),
    .result(res8), .xa(xa8), .xb(xb8), .xy(xy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(logic [3:0] m, int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    req8 = '0;
    op_a = '0;
    op_b = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for done; reports what it saw, compares nothing.
  task automatic wait_done(output logic got, output int id,
                           output logic [15:0] res, output int n,
                           output logic [3:0] g0);
    got = 1'b0;
    id = -1;
    res = '0;
    g0 = '0;
    for (n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) g0 = gnt;
      if (done) begin
        got = 1'b1;
        id = int'(done_id);
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, done, done_id, result, xa, xb} !== '0) begin
      failures++;
      $display("FAIL reset16 got %h want 0",
               {gnt, busy, done, done_id, result, xa, xb});
    end
    checks++;
    if ({gnt8, busy8, done8, id8, res8, xa8, xb8} !== '0) begin
      failures++;
      $display("FAIL reset8 got %h want 0",
               {gnt8, busy8, done8, id8, res8, xa8, xb8});
    end
  endtask

  task automatic test_single();
    logic [15:0] a, b;
    apply_reset();
    a = 16'hA5F0;
    b = 16'h5A0F;
    op_a[15:0] = a;
    op_b[15:0] = b;
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_gnt gnt=%b busy=%b want 0001/1", gnt, busy);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (xa !== a[k*4 +: 4] || xb !== b[k*4 +: 4]) begin
        failures++;
        $display("FAIL single_nib%0d xa/xb=%h/%h want %h/%h",
                 k, xa, xb, a[k*4 +: 4], b[k*4 +: 4]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || result !== 16'hFFFF || done_id !== 2'd0) begin
      failures++;
      $display("FAIL single_done done=%b res=%h id=%0d want 1/ffff/0",
               done, result, done_id);
    end
    req = '0;
    tick();
    checks++;
    if (done !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 ||
        xa !== 4'h0 || result !== 16'hFFFF) begin
      failures++;
      $display("FAIL single_after done=%b gnt=%b busy=%b xa=%h res=%h",
               done, gnt, busy, xa, result);
    end
  endtask

  task automatic test_all_four();
    logic got;
    int id, n, mp, exp;
    logic [15:0] res;
    logic [3:0] g0, m;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      op_a[i*16 +: 16] = 16'hFFFF;
      op_b[i*16 +: 16] = {4{4'(i)}};
    end
    m = 4'hF;
    mp = 0;
    req = m;
    for (int i = 0; i < 4; i++) begin
      exp = pick(m, mp);
      wait_done(got, id, res, n, g0);
      checks++;
      if (got !== 1'b1 || id != i || id != exp) begin
        failures++;
        $display("FAIL all4_order%0d got=%b id=%0d want %0d", i, got, id, i);
      end
      checks++;
      if (res !== (16'hFFFF ^ {4{4'(i)}})) begin
        failures++;
        $display("FAIL all4_res%0d res=%h want %h", i, res,
                 16'hFFFF ^ {4{4'(i)}});
      end
      if (id >= 0) begin
        m[id] = 1'b0;
        mp = (id + 1) % 4;
      end
      req = m;
    end
  endtask

  task automatic test_back_to_back();
    logic got;
    int id, n, mp, exp, prev;
    logic [15:0] res;
    logic [3:0] g0;
    apply_reset();
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    req = 4'b0101;
    mp = 0;
    prev = -1;
    for (int r = 0; r < 5; r++) begin
      exp = pick(4'b0101, mp);
      wait_done(got, id, res, n, g0);
      checks++;
      if (got !== 1'b1 || id != exp || id == prev) begin
        failures++;
        $display("FAIL b2b_id%0d id=%0d want %0d prev=%0d", r, id, exp, prev);
      end
      checks++;
      if (n != ((r == 0) ? 5 : 6) ||
          res !== (op_a[exp*16 +: 16] ^ op_b[exp*16 +: 16])) begin
        failures++;
        $display("FAIL b2b_timing%0d cycles=%0d res=%h want %0d/%h", r, n,
                 res, (r == 0) ? 5 : 6,
                 op_a[exp*16 +: 16] ^ op_b[exp*16 +: 16]);
      end
      prev = id;
      mp = (exp + 1) % 4;
    end
    req = '0;
  endtask

  task automatic test_drop();
    logic got;
    int id, n;
    logic [15:0] res, a, b;
    logic [3:0] g0;
    apply_reset();
    a = 16'($urandom);
    b = 16'($urandom);
    op_a[31:16] = a;
    op_b[31:16] = b;
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL drop_gnt gnt=%b want 0010", gnt);
    end
    tick();
    req = '0;
    op_a[31:16] = ~a;
    op_b[31:16] = b ^ 16'h1234;
    wait_done(got, id, res, n, g0);
    checks++;
    if (got !== 1'b1 || id != 1 || n != 3 || res !== (a ^ b)) begin
      failures++;
      $display("FAIL drop_done got=%b id=%0d n=%0d res=%h want 1/1/3/%h",
               got, id, n, res, a ^ b);
    end
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle gnt=%b busy=%b want 0/0", gnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    int id, n;
    logic [15:0] res;
    logic [3:0] g0;
    apply_reset();
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    req = 4'b0100;
    wait_done(got, id, res, n, g0);
    checks++;
    if (got !== 1'b1 || id != 2) begin
      failures++;
      $display("FAIL rmid_first got=%b id=%0d want 1/2", got, id);
    end
    req = 4'b1000;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL rmid_gnt gnt=%b want 1000", gnt);
    end
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, done, done_id, result, xa, xb} !== '0) begin
      failures++;
      $display("FAIL rmid_async got %h want 0",
               {gnt, busy, done, done_id, result, xa, xb});
    end
    req = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rmid_hold%0d done=%b busy=%b want 0/0", k, done, busy);
      end
    end
    rst_n = 1'b1;
    wait_done(got, id, res, n, g0);
    checks++;
    if (got !== 1'b1 || id != 2 || g0 !== 4'b0100) begin
      failures++;
      $display("FAIL rmid_ptr got=%b id=%0d g0=%b want 1/2/0100",
               got, id, g0);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic got;
    int id, n, mp, exp;
    logic [15:0] res, want;
    logic [3:0] g0, m;
    apply_reset();
    mp = 0;
    for (int r = 0; r < 20; r++) begin
      m = 4'($urandom_range(1, 15));
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      req = m;
      exp = pick(m, mp);
      want = op_a[exp*16 +: 16] ^ op_b[exp*16 +: 16];
      wait_done(got, id, res, n, g0);
      checks++;
      if (got !== 1'b1 || id != exp || res !== want) begin
        failures++;
        $display("FAIL rand%0d got=%b id=%0d res=%h want %0d/%h",
                 r, got, id, res, exp, want);
      end
      checks++;
      if (n != 5 || g0 !== (4'b0001 << exp)) begin
        failures++;
        $display("FAIL rand_tg%0d n=%0d gnt=%b want 5/%b",
                 r, n, g0, 4'b0001 << exp);
      end
      mp = (exp + 1) % 4;
      req = '0;
      tick();
    end
  endtask

  task automatic test_w8();
    int n;
    logic [7:0] a, b;
    apply_reset();
    a8[7:0] = 8'h3C;
    b8[7:0] = 8'h0F;
    a = 8'($urandom);
    b = 8'($urandom);
    a8[15:8] = a;
    b8[15:8] = b;
    req8 = 2'b11;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (done8) break;
    end
    checks++;
    if (n != 3 || res8 !== 8'h33 || id8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_first n=%0d res=%h id=%0d want 3/33/0", n, res8, id8);
    end
    req8 = 2'b10;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (done8) break;
    end
    checks++;
    if (n != 4 || res8 !== (a ^ b) || id8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_second n=%0d res=%h id=%0d want 4/%h/1",
               n, res8, id8, a ^ b);
    end
    req8 = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_random();
    test_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
